// File: rtl/stream_ser_pkg.sv
// ---------------------------------------------------------------------------
// stream_ser_pkg
// Shared definitions for the stream serializer.
//   - ser_state_e   : FSM state encoding (IDLE = no word held, SHIFT = word held)
//   - serRatio      : number of output beats per input word
//   - serCntWidth   : width of the beat counter for a given ratio
//   - serConfigOk   : legality check on the WIDTH / OUT_WIDTH pairing
// ---------------------------------------------------------------------------
package stream_ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   // Beats per word; only meaningful when serConfigOk() holds.
   function automatic int serRatio(input int width, input int outWidth);
      return width / outWidth;
   endfunction

   // Counter wide enough to index every beat of a word.
   function automatic int serCntWidth(input int ratio);
      return (ratio < 2) ? 1 : $clog2(ratio);
   endfunction

   // The word must split into a whole number of beats, at least two of them.
   function automatic bit serConfigOk(input int width, input int outWidth);
      if (outWidth <= 0) return 1'b0;
      return ((width % outWidth) == 0) && ((width / outWidth) >= 2);
   endfunction

endpackage

// File: rtl/stream_serializer_if.sv
// ---------------------------------------------------------------------------
// stream_serializer_if
// Bundles the wide input stream and the narrow output stream of the
// serializer.
//   in_data   [WIDTH]      word to serialize          (master -> slave)
//   in_valid               in_data is valid           (master -> slave)
//   in_ready               serializer takes the word  (slave  -> master)
//   out_data  [OUT_WIDTH]  current beat               (slave  -> master)
//   out_valid              out_data is valid          (slave  -> master)
//   out_ready              downstream takes the beat  (master -> slave)
//   in_last / out_last     word-end marker, only when SERIALIZER_LAST_EN
//                          is defined
// The master modport is the environment around the serializer (upstream
// producer plus downstream consumer); the slave modport is the serializer.
// ---------------------------------------------------------------------------
interface stream_serializer_if #(
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 8
);

   logic [WIDTH-1:0]     in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
`ifdef SERIALIZER_LAST_EN
   logic                 in_last;
   logic                 out_last;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last
   );
`else
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );
`endif

endinterface

// File: rtl/stream_serializer.sv
// ---------------------------------------------------------------------------
// stream_serializer
// Width down-converter: accepts one WIDTH-bit word per input handshake and
// emits it as RATIO = WIDTH/OUT_WIDTH beats of OUT_WIDTH bits. A new word can
// be accepted in the same cycle the final beat of the previous word leaves,
// so back-to-back words keep the output fully busy.
//
// Parameters:
//   WIDTH     input word width (multiple of OUT_WIDTH)
//   OUT_WIDTH output beat width (RATIO must be >= 2)
//   MSB_FIRST 0: low slice first, 1: high slice first
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous, active-low reset
//   bus    stream_serializer_if.slave (in_* word side, out_* beat side)
// Optional feature macro: SERIALIZER_LAST_EN adds in_last/out_last; out_last
//   marks the final beat of a word that arrived with in_last set.
// ---------------------------------------------------------------------------
module stream_serializer
   import stream_ser_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 8,
   parameter int MSB_FIRST = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   stream_serializer_if.slave  bus
);

   localparam int              RATIO     = serRatio(WIDTH, OUT_WIDTH);
   localparam int              CNT_W     = serCntWidth(RATIO);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

   // Refuse to elaborate a configuration that cannot be split evenly.
   generate
      if (!serConfigOk(WIDTH, OUT_WIDTH)) begin : g_badConfig
         $error("stream_serializer: WIDTH must be a multiple of OUT_WIDTH with RATIO >= 2");
      end
   endgenerate

   ser_state_e        r_state;
   ser_state_e        w_nextState;
   logic [CNT_W-1:0]  r_beatCnt;
   logic [CNT_W-1:0]  w_nextBeatCnt;
   logic [WIDTH-1:0]  r_dataQ;
   logic [CNT_W-1:0]  w_sliceIdx;
   logic              w_lastBeat;
   logic              w_load;
   logic              w_inReady;
   logic              w_outValid;

   assign w_lastBeat = (r_beatCnt == LAST_BEAT);

   // Next-state and handshake logic. in_ready depends on out_ready only in
   // SHIFT, where the final beat leaving frees the holding register for the
   // next word in the same cycle; this is what removes the bubble between
   // back-to-back words. The counter returns to 0 whenever the word is
   // finished so the idle output shows slice 0.
   always_comb begin
      w_nextState   = r_state;
      w_nextBeatCnt = r_beatCnt;
      w_load        = 1'b0;
      w_inReady     = 1'b0;
      w_outValid    = 1'b0;
      case (r_state)
         IDLE: begin
            w_inReady = 1'b1;
            if (bus.in_valid) begin
               w_load        = 1'b1;
               w_nextBeatCnt = '0;
               w_nextState   = SHIFT;
            end
         end
         SHIFT: begin
            w_outValid = 1'b1;
            w_inReady  = bus.out_ready && w_lastBeat;
            if (bus.out_ready) begin
               if (!w_lastBeat) begin
                  w_nextBeatCnt = r_beatCnt + CNT_W'(1);
               end else if (bus.in_valid) begin
                  w_load        = 1'b1;
                  w_nextBeatCnt = '0;
               end else begin
                  w_nextState   = IDLE;
                  w_nextBeatCnt = '0;
               end
            end
         end
      endcase
   end

   // State and beat counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_beatCnt <= '0;
      end else begin
         r_state   <= w_nextState;
         r_beatCnt <= w_nextBeatCnt;
      end
   end

   // Holding register for the word being serialized; it only changes when
   // a new word is accepted, so stalls leave the current beat untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dataQ <= '0;
      end else if (w_load) begin
         r_dataQ <= bus.in_data;
      end
   end

   // Beat order: the counter always runs upward, MSB-first just mirrors
   // which slice the counter points at.
   generate
      if (MSB_FIRST != 0) begin : g_msbFirst
         assign w_sliceIdx = LAST_BEAT - r_beatCnt;
      end else begin : g_lsbFirst
         assign w_sliceIdx = r_beatCnt;
      end
   endgenerate

   assign bus.in_ready  = w_inReady;
   assign bus.out_valid = w_outValid;
   assign bus.out_data  = r_dataQ[int'(w_sliceIdx) * OUT_WIDTH +: OUT_WIDTH];

`ifdef SERIALIZER_LAST_EN
   logic r_lastQ;

   // The word-end marker travels with the word and is only shown on the
   // final beat; it follows the counter, so it is stable through a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lastQ <= 1'b0;
      end else if (w_load) begin
         r_lastQ <= bus.in_last;
      end
   end

   assign bus.out_last = w_outValid && r_lastQ && w_lastBeat;
`endif

endmodule

// File: tb/tb_stream_serializer.sv
// ---------------------------------------------------------------------------
// tb_stream_serializer
// Drives two serializers (LSB-first and MSB-first) with identical stimulus.
// applyStimulus queues the expected beats of each word; a monitor per DUT
// pops and compares on every output handshake. Directed checks cover reset,
// latency, back-to-back throughput, backpressure and reset mid-word.
// Optional feature macro: SERIALIZER_LAST_EN (adds out_last checking).
// ---------------------------------------------------------------------------
module tb_stream_serializer;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] inData;
   logic        inValid;
   logic        outReady;
`ifdef SERIALIZER_LAST_EN
   logic        inLast;
`endif

   int nCompared;
   int nMismatched;

   beat_t q0[$];
   beat_t q1[$];

   stream_serializer_if #(.WIDTH(32), .OUT_WIDTH(8)) bus0 ();
   stream_serializer_if #(.WIDTH(32), .OUT_WIDTH(8)) bus1 ();

   assign bus0.in_data   = inData;
   assign bus0.in_valid  = inValid;
   assign bus0.out_ready = outReady;
   assign bus1.in_data   = inData;
   assign bus1.in_valid  = inValid;
   assign bus1.out_ready = outReady;
`ifdef SERIALIZER_LAST_EN
   assign bus0.in_last   = inLast;
   assign bus1.in_last   = inLast;
`endif

   stream_serializer #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0.slave)
   );

   stream_serializer #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point so every check steps the same counters.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Queue the expected beats of one word, present it and hold in_valid
   // until the accepting edge. waits reports how many cycles in_ready was
   // sampled before it was seen high (1 = accepted on the first cycle).
   task automatic applyStimulus(input logic [31:0] word, input logic last, output int waits);
      beat_t b;
      for (int k = 0; k < 4; k++) begin
         b.data = word[8*k +: 8];
         b.last = last && (k == 3);
         q0.push_back(b);
         b.data = word[8*(3-k) +: 8];
         q1.push_back(b);
      end
      inData  = word;
      inValid = 1'b1;
`ifdef SERIALIZER_LAST_EN
      inLast  = last;
`endif
      waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (!bus0.in_ready && waits < 50);
      if (!bus0.in_ready) checkOutput("acceptTimeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   // Count consecutive cycles of out_valid starting at the current sample.
   task automatic countValid(output int n);
      n = 0;
      while (bus0.out_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
   endtask

   // LSB-first scoreboard monitor.
   always @(negedge clk) begin
      if (rst_n && bus0.out_valid && bus0.out_ready) begin
         if (q0.size() == 0) begin
            checkOutput("dut0UnexpectedBeat", {24'd0, bus0.out_data}, 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = q0.pop_front();
            checkOutput("dut0Beat", {24'd0, bus0.out_data}, {24'd0, e.data});
`ifdef SERIALIZER_LAST_EN
            checkOutput("dut0Last", {31'd0, bus0.out_last}, {31'd0, e.last});
`endif
         end
      end
   end

   // MSB-first scoreboard monitor.
   always @(negedge clk) begin
      if (rst_n && bus1.out_valid && bus1.out_ready) begin
         if (q1.size() == 0) begin
            checkOutput("dut1UnexpectedBeat", {24'd0, bus1.out_data}, 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = q1.pop_front();
            checkOutput("dut1Beat", {24'd0, bus1.out_data}, {24'd0, e.data});
`ifdef SERIALIZER_LAST_EN
            checkOutput("dut1Last", {31'd0, bus1.out_last}, {31'd0, e.last});
`endif
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int w0;
      int w1;
      int n;
      nCompared   = 0;
      nMismatched = 0;
      rst_n    = 1'b0;
      inData   = '0;
      inValid  = 1'b0;
      outReady = 1'b1;
`ifdef SERIALIZER_LAST_EN
      inLast   = 1'b0;
`endif

      // Reset values.
      #3;
      checkOutput("rstOutValid0", {31'd0, bus0.out_valid}, 32'd0);
      checkOutput("rstInReady0",  {31'd0, bus0.in_ready},  32'd1);
      checkOutput("rstOutData0",  {24'd0, bus0.out_data},  32'd0);
      checkOutput("rstOutValid1", {31'd0, bus1.out_valid}, 32'd0);
      checkOutput("rstInReady1",  {31'd0, bus1.in_ready},  32'd1);
      checkOutput("rstOutData1",  {24'd0, bus1.out_data},  32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idleOutValid", {31'd0, bus0.out_valid}, 32'd0);
      checkOutput("idleInReady",  {31'd0, bus0.in_ready},  32'd1);
      @(posedge clk);
      #1;

      // Single word: first beat one cycle after acceptance, four beats total.
      applyStimulus(32'hAABBCCDD, 1'b0, w0);
      inValid = 1'b0;
      @(negedge clk);
      checkOutput("latencyValid",   {31'd0, bus0.out_valid}, 32'd1);
      checkOutput("latencyData0",   {24'd0, bus0.out_data},  32'h0000_00DD);
      checkOutput("latencyData1",   {24'd0, bus1.out_data},  32'h0000_00AA);
      countValid(n);
      checkOutput("singleBeatCount", n, 32'd4);

      // Back-to-back words: in_ready seen immediately from idle, then only on
      // the final beat of the first word; eight beats with no gap.
      @(posedge clk);
      #1;
      applyStimulus(32'h03020100, 1'b0, w0);
      applyStimulus(32'h07060504, 1'b0, w1);
      inValid = 1'b0;
      checkOutput("b2bFirstWait",  w0, 32'd1);
      checkOutput("b2bSecondWait", w1, 32'd4);
      @(negedge clk);
      countValid(n);
      checkOutput("b2bTailBeats", n, 32'd4);

      // Backpressure while beat CC is on the output.
      @(posedge clk);
      #1;
      applyStimulus(32'hAABBCCDD, 1'b0, w0);
      inValid = 1'b0;
      @(posedge clk);
      #1 outReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("stallData",    {24'd0, bus0.out_data},  32'h0000_00CC);
         checkOutput("stallValid",   {31'd0, bus0.out_valid}, 32'd1);
         checkOutput("stallInReady", {31'd0, bus0.in_ready},  32'd0);
      end
      @(posedge clk);
      #1 outReady = 1'b1;
      @(negedge clk);
      countValid(n);
      checkOutput("stallTailBeats", n, 32'd3);

      // Reset after two beats: the rest of the word must vanish.
      @(posedge clk);
      #1;
      applyStimulus(32'hAABBCCDD, 1'b0, w0);
      inValid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      q0.delete();
      q1.delete();
      #2;
      checkOutput("midRstOutValid", {31'd0, bus0.out_valid}, 32'd0);
      checkOutput("midRstInReady",  {31'd0, bus0.in_ready},  32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("postRstNoBeat", {31'd0, bus0.out_valid}, 32'd0);
      end
      checkOutput("postRstInReady", {31'd0, bus0.in_ready}, 32'd1);

      // First word after reset starts at beat 0.
      @(posedge clk);
      #1;
      applyStimulus(32'h44332211, 1'b0, w0);
      inValid = 1'b0;
      @(negedge clk);
      checkOutput("postRstFirstBeat", {24'd0, bus0.out_data}, 32'h0000_0011);
      countValid(n);
      checkOutput("postRstBeatCount", n, 32'd4);

`ifdef SERIALIZER_LAST_EN
      // Word-end marker only on the final beat of the marked word.
      @(posedge clk);
      #1;
      applyStimulus(32'h11223344, 1'b1, w0);
      applyStimulus(32'h55667788, 1'b0, w1);
      inValid = 1'b0;
      inLast  = 1'b0;
      @(negedge clk);
      countValid(n);
      checkOutput("lastTailBeats", n, 32'd4);
`endif

      // Everything queued must have been seen.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("dut0QueueEmpty", q0.size(), 32'd0);
      checkOutput("dut1QueueEmpty", q1.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
